// File: rtl/lab7soc_pio_pkg.sv
// Shared register map and edge-select encodings for the lab7soc PIO input ports.
package lab7soc_pio_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned BUS_W  = 32;

    localparam logic [ADDR_W-1:0] ADDR_DATA    = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_RSVD    = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 2'd3;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/lab7soc_pio_sync_edge.sv
// Two-flop synchronizer plus delay flop; emits the synchronized value and the selected per-bit edge.
module lab7soc_pio_sync_edge
    import lab7soc_pio_pkg::*;
#(
    parameter int unsigned       WIDTH       = 32,
    parameter int unsigned       EDGE_TYPE   = EDGE_RISE,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_q,
    output logic [WIDTH-1:0] edge_c
);

    logic [WIDTH-1:0] sync0;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] dly;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0 <= RESET_VALUE;
            sync1 <= RESET_VALUE;
            dly   <= RESET_VALUE;
        end else begin
            sync0 <= in_port;
            sync1 <= sync0;
            dly   <= sync1;
        end
    end

    assign rise   = sync1 & ~dly;
    assign fall   = ~sync1 & dly;
    assign sync_q = sync1;

    generate
        if (EDGE_TYPE == EDGE_FALL) begin : g_fall
            assign edge_c = fall;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
            assign edge_c = rise | fall;
        end else begin : g_rise
            assign edge_c = rise;
        end
    endgenerate

endmodule

// File: rtl/lab7soc_frame_status_in.sv
// Avalon-MM input port for raycaster status bits with sticky edge capture and maskable irq.
// Optional FRAME_STATUS_BIT_CLEAR_EN: edgecapture writes clear only bits written as 1.
module lab7soc_frame_status_in
    import lab7soc_pio_pkg::*;
#(
    parameter int unsigned       WIDTH       = 32,
    parameter int unsigned       EDGE_TYPE   = EDGE_RISE,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [BUS_W-1:0]  writedata,
    output logic [BUS_W-1:0]  readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq
);

    logic [WIDTH-1:0] data_sync;
    logic [WIDTH-1:0] edge_bits;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] clr_bits;
    logic [WIDTH-1:0] rd_mux;
    logic             wr_en;
    logic             rd_en;

    lab7soc_pio_sync_edge #(
        .WIDTH       (WIDTH),
        .EDGE_TYPE   (EDGE_TYPE),
        .RESET_VALUE (RESET_VALUE)
    ) u_sync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .sync_q  (data_sync),
        .edge_c  (edge_bits)
    );

    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect & ~read_n;

    // Bits cleared by an edgecapture write this cycle.
    always_comb begin
        clr_bits = '0;
        if (wr_en && address == ADDR_EDGECAP) begin
`ifdef FRAME_STATUS_BIT_CLEAR_EN
            clr_bits = writedata[WIDTH-1:0];
`else
            clr_bits = '1;
`endif
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux = data_sync;
            ADDR_IRQMASK: rd_mux = irq_mask;
            ADDR_EDGECAP: rd_mux = edge_capture;
            default:      rd_mux = '0;
        endcase
    end

    // A new edge overrides a simultaneous clear on the same bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
            irq_mask     <= '0;
            readdata     <= '0;
        end else begin
            edge_capture <= (edge_capture & ~clr_bits) | edge_bits;
            if (wr_en && address == ADDR_IRQMASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            if (rd_en) begin
                readdata <= BUS_W'(rd_mux);
            end
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_lab7soc_frame_status_in.sv
// Directed self-checking bench for lab7soc_frame_status_in (default parameters).
module tb_lab7soc_frame_status_in;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] in_port;
    logic        irq;

    int compared = 0;
    int mismatched = 0;

    lab7soc_frame_status_in dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        tick();
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic settle(input logic [31:0] v);
        in_port = v;
        repeat (4) tick();
    endtask

    initial begin
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; read_n = 1'b1;
        write_n = 1'b1; writedata = 32'h0; in_port = 32'h0;
        #3;
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Data read after synchronizer settles; mask still 0 so no irq.
        settle(32'h0000_00A5);
        bus_read(2'd0);
        check("read_data_a5", readdata, 32'h0000_00A5);
        check("irq_mask0", {31'h0, irq}, 32'h0);
        bus_read(2'd3);
        check("edgecap_a5", readdata, 32'h0000_00A5);
        bus_read(2'd2);
        check("irqmask_reset", readdata, 32'h0);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd3);
        check("edgecap_cleared", readdata, 32'h0);
        bus_read(2'd1);
        check("rsvd_zero", readdata, 32'h0);

        // Rising edge on bit0 with mask 1: irq exactly 3 edges after the change.
        bus_write(2'd2, 32'h1);
        settle(32'h0000_00A4);
        bus_write(2'd3, 32'hFFFF_FFFF);
        check("irq_before_edge", {31'h0, irq}, 32'h0);
        in_port = 32'h0000_00A5;
        tick();
        check("irq_edge1", {31'h0, irq}, 32'h0);
        tick();
        check("irq_edge2", {31'h0, irq}, 32'h0);
        tick();
        check("irq_edge3", {31'h0, irq}, 32'h1);
        bus_read(2'd3);
        check("edgecap_bit0", readdata, 32'h1);

        // Clearing write lands in the same cycle as a new edge: set wins.
        settle(32'h0000_00A4);
        in_port = 32'h0000_00A5;
        tick(); tick();
        bus_write(2'd3, 32'h1);
        check("setwins_irq", {31'h0, irq}, 32'h1);
        bus_read(2'd3);
        check("setwins_edgecap", readdata, 32'h1);

        // Partial clear with edgecapture = 0x6.
        settle(32'h0000_00A1);
        bus_write(2'd3, 32'hFFFF_FFFF);
        settle(32'h0000_00A7);
        bus_read(2'd3);
        check("edgecap_6", readdata, 32'h6);
        bus_write(2'd3, 32'h2);
        bus_read(2'd3);
`ifdef FRAME_STATUS_BIT_CLEAR_EN
        check("partial_clear", readdata, 32'h4);
`else
        check("partial_clear", readdata, 32'h0);
`endif

        // Mask toggling with edgecapture = 0x1.
        settle(32'h0000_00A6);
        bus_write(2'd3, 32'hFFFF_FFFF);
        settle(32'h0000_00A7);
        check("mask_irq_on", {31'h0, irq}, 32'h1);
        address = 2'd2; writedata = 32'h0; chipselect = 1'b1; write_n = 1'b0;
        #1;
        check("mask_wr_no_comb", {31'h0, irq}, 32'h1);
        tick();
        chipselect = 1'b0; write_n = 1'b1;
        check("mask0_irq_off", {31'h0, irq}, 32'h0);
        bus_write(2'd2, 32'h1);
        check("mask1_irq_on", {31'h0, irq}, 32'h1);

        // Writes to address 0 are ignored.
        bus_write(2'd0, 32'h0);
        bus_read(2'd3);
        check("wr_addr0_ignored", readdata, 32'h1);
        bus_read(2'd0);
        check("read_data_a7", readdata, 32'h0000_00A7);

        // Asynchronous reset mid-cycle.
        check("pre_reset_irq", {31'h0, irq}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_irq", {31'h0, irq}, 32'h0);
        check("async_readdata", readdata, 32'h0);
        check("async_edgecap", dut.edge_capture, 32'h0);
        #3;
        reset_n = 1'b1;
        repeat (4) tick();
        check("post_reset_irq", {31'h0, irq}, 32'h0);
        bus_read(2'd2);
        check("post_reset_mask", readdata, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
